// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one byte-level I2C master between two requesters.
// A grant lasts a whole START..STOP transaction so byte streams never interleave.
// A per-grant watchdog forces a STOP when the owner stalls or walks away mid-transaction.
module i2c_master_arbiter #(
    parameter int HOLD_TIMEOUT   = 1024,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       i_clk_i2c,
    input  logic       i_reset,
    input  logic       i_r0_req,
    input  logic       i_r0_start,
    input  logic       i_r0_end,
    input  logic       i_r0_write,
    input  logic       i_r0_read,
    input  logic [7:0] i_r0_out,
    output logic       o_r0_gnt,
    output logic       o_r0_ready,
    output logic       o_r0_error,
    output logic [7:0] o_r0_in,
    input  logic       i_r1_req,
    input  logic       i_r1_start,
    input  logic       i_r1_end,
    input  logic       i_r1_write,
    input  logic       i_r1_read,
    input  logic [7:0] i_r1_out,
    output logic       o_r1_gnt,
    output logic       o_r1_ready,
    output logic       o_r1_error,
    output logic [7:0] o_r1_in,
    output logic       o_i2c_start,
    output logic       o_i2c_end,
    output logic       o_i2c_write,
    output logic       o_i2c_read,
    output logic [7:0] o_i2c_out,
    input  logic [7:0] i_i2c_in,
    input  logic       i_i2c_ready,
    input  logic       i_i2c_error,
    output logic       o_timeout_flag
);
    localparam int WDW = $clog2(HOLD_TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, OWN, BUSY, FORCE, RELEASE} state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_ptr;
    logic           r_in_txn;
    logic           r_end_pend;
    logic           r_first;
    logic           r_fsent;
    logic [1:0]     r_err;
    logic [7:0]     r_in0;
    logic [7:0]     r_in1;
    logic [WDW-1:0] r_wd;

    logic       w_req, w_start, w_end, w_write, w_read, w_accept, w_win, w_held, w_own, w_tmo;
    logic [7:0] w_out;

    assign w_req    = r_owner ? i_r1_req   : i_r0_req;
    assign w_start  = r_owner ? i_r1_start : i_r0_start;
    assign w_end    = r_owner ? i_r1_end   : i_r0_end;
    assign w_write  = r_owner ? i_r1_write : i_r0_write;
    assign w_read   = r_owner ? i_r1_read  : i_r0_read;
    assign w_out    = r_owner ? i_r1_out   : i_r0_out;
    assign w_own    = r_state == OWN;
    assign w_held   = r_state == OWN || r_state == BUSY || r_state == FORCE;
    assign w_accept = w_own && i_i2c_ready && (w_start || w_end || w_write || w_read);
    assign w_tmo    = r_wd == WDW'(HOLD_TIMEOUT - 1);
    // r_ptr names the requester that wins the next tie under round-robin
    assign w_win    = (i_r0_req && i_r1_req) ? (FIXED_PRIORITY ? 1'b0 : r_ptr) : i_r1_req;

    assign o_r0_gnt   = w_held && !r_owner;
    assign o_r1_gnt   = w_held && r_owner;
    assign o_r0_ready = w_own && !r_owner && i_i2c_ready;
    assign o_r1_ready = w_own && r_owner && i_i2c_ready;
    assign o_r0_error = r_err[0];
    assign o_r1_error = r_err[1];
    assign o_r0_in    = r_in0;
    assign o_r1_in    = r_in1;

    // Arbitration FSM; r_first masks the cycle in which the master has not yet seen our strobe
    always_ff @(posedge i_clk_i2c or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_owner        <= 1'b0;
            r_ptr          <= 1'b0;
            r_in_txn       <= 1'b0;
            r_end_pend     <= 1'b0;
            r_first        <= 1'b0;
            r_fsent        <= 1'b0;
            r_err          <= 2'b00;
            r_in0          <= 8'h00;
            r_in1          <= 8'h00;
            r_wd           <= '0;
            o_i2c_start    <= 1'b0;
            o_i2c_end      <= 1'b0;
            o_i2c_write    <= 1'b0;
            o_i2c_read     <= 1'b0;
            o_i2c_out      <= 8'h00;
            o_timeout_flag <= 1'b0;
        end else begin
            o_i2c_start <= 1'b0;
            o_i2c_end   <= 1'b0;
            o_i2c_write <= 1'b0;
            o_i2c_read  <= 1'b0;
            o_i2c_out   <= 8'h00;
            r_err       <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (i_r0_req || i_r1_req) begin
                        r_owner <= w_win;
                        r_ptr   <= ~w_win;
                        r_wd    <= '0;
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (w_accept) begin
                        o_i2c_start <= w_start;
                        o_i2c_end   <= w_end;
                        o_i2c_write <= w_write;
                        o_i2c_read  <= w_read;
                        o_i2c_out   <= w_out;
                        r_wd        <= '0;
                        r_first     <= 1'b1;
                        if (w_start) r_in_txn <= 1'b1;
                        if (w_end) r_end_pend <= 1'b1;
                        r_state     <= BUSY;
                    end else if (!w_req || w_tmo) begin
                        r_fsent <= 1'b0;
                        r_state <= r_in_txn ? FORCE : RELEASE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                BUSY: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (i_i2c_error) begin
                        r_err[r_owner] <= 1'b1;
                        r_in_txn       <= 1'b0;
                        r_end_pend     <= 1'b0;
                        r_state        <= RELEASE;
                    end else if (i_i2c_ready) begin
                        if (r_owner) r_in1 <= i_i2c_in;
                        else r_in0 <= i_i2c_in;
                        r_in_txn   <= r_in_txn && !r_end_pend;
                        r_end_pend <= 1'b0;
                        r_state    <= r_end_pend ? RELEASE : OWN;
                    end
                end
                FORCE: begin
                    if (!r_fsent) begin
                        if (i_i2c_ready) begin
                            o_i2c_end      <= 1'b1;
                            o_timeout_flag <= 1'b1;
                            r_err[r_owner] <= 1'b1;
                            r_fsent        <= 1'b1;
                            r_first        <= 1'b1;
                            r_in_txn       <= 1'b0;
                            r_end_pend     <= 1'b0;
                        end
                    end else if (r_first) begin
                        r_first <= 1'b0;
                    end else if (i_i2c_ready) begin
                        r_state <= RELEASE;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
